// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock.
// Unsigned DW-bit dividend by VW-bit divisor, start/busy/done handshake.
// Divide-by-zero completes in one cycle with an all-ones quotient and dbz set.
module seq_divider #(
    parameter int unsigned DW = 6,
    parameter int unsigned VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LastIter = CW'(DW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDz
    } state_e;

    state_e        state_q, state_d;
    // D doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    logic [DW-1:0] d_q, d_d;
    logic [VW-1:0] v_q, v_d;
    logic [VW:0]   p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    // One restoring step; P is one bit wider than V so the compare never overflows.
    logic [VW:0]   p_shift;
    logic [VW:0]   v_ext;
    logic          q_bit;
    logic [VW:0]   p_next;
    logic [DW-1:0] d_next;

    // Datapath for a single iteration
    always_comb begin
        p_shift = {p_q[VW-1:0], d_q[DW-1]};
        v_ext   = {1'b0, v_q};
        q_bit   = (p_shift >= v_ext);
        p_next  = q_bit ? (p_shift - v_ext) : p_shift;
        d_next  = {d_q[DW-2:0], q_bit};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        v_d         = v_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor != '0) begin
                        d_d     = dividend;
                        v_d     = divisor;
                        p_d     = '0;
                        cnt_d   = '0;
                        state_d = StCalc;
                    end else begin
                        state_d = StDz;
                    end
                end
            end
            StCalc: begin
                d_d   = d_next;
                p_d   = p_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastIter) begin
                    // Remainder < divisor, so the top bit of P is zero here.
                    quotient_d  = d_next;
                    remainder_d = p_next[VW-1:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            StDz: begin
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            d_q         <= '0;
            v_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            v_q         <= v_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule
